// File: rtl/rmh_pkg.sv
// Shared widths, entry layout {tid, addr, data} and entry type for the read-miss handler.
// Default widths come from the AXI/TID macros when the build provides them.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 4
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

package rmh_pkg;
  localparam int RMH_ADDR_WIDTH = `AXI_ADDR_WIDTH;
  localparam int RMH_DATA_WIDTH = `AXI_DATA_WIDTH;
  localparam int RMH_TID_WIDTH  = `TID_WIDTH;
  localparam int RMH_ID_WIDTH   = `AXI_ID_WIDTH;

  localparam int DATA_LSB    = 0;
  localparam int ADDR_LSB    = DATA_LSB + RMH_DATA_WIDTH;
  localparam int TID_LSB     = ADDR_LSB + RMH_ADDR_WIDTH;
  localparam int ENTRY_WIDTH = TID_LSB + RMH_TID_WIDTH;

  typedef struct packed {
    logic [RMH_TID_WIDTH-1:0]  tid;
    logic [RMH_ADDR_WIDTH-1:0] addr;
    logic [RMH_DATA_WIDTH-1:0] data;
  } rmh_entry_t;
endpackage

// File: rtl/rmh_resp_buf.sv
// DEPTH-entry circular buffer of paired responses; head is mem[rd], visible the cycle after push.
// No internal flow control: the caller never pushes when full nor pops when empty.
module rmh_resp_buf
  import rmh_pkg::*;
#(
  parameter int WIDTH = ENTRY_WIDTH,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_dat
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr;
  logic [PW-1:0]    rd;

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= push_dat;
        wr      <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd];

endmodule

// File: rtl/read_miss_handler_mo.sv
// Pairs CXL read beats with the miss-FIFO head, buffers them, and forks each to ROB and fill Arbiter.
// Latency 1 accept-to-output; 1 response/cycle; each side may stall independently, entry retires after both.
module read_miss_handler_mo
  import rmh_pkg::*;
#(
  parameter int ADDR_WIDTH  = `AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH  = `AXI_DATA_WIDTH,
  parameter int TID_WIDTH   = `TID_WIDTH,
  parameter int ID_WIDTH    = `AXI_ID_WIDTH,
  parameter int DEPTH       = 4,
  parameter bit CHECK_ID    = 1'b1,
  parameter int WDATA_WIDTH = ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic [DATA_WIDTH-1:0]           data_i,
  input  logic [ID_WIDTH-1:0]             rid_i,
  output logic                            read_en_o,
  input  logic                            empty_i,
  input  logic [ADDR_WIDTH+TID_WIDTH-1:0] ar_i,
  output logic                            write_en_o,
  input  logic                            full_i,
  output logic [DATA_WIDTH+TID_WIDTH-1:0] wdata_rob_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [WDATA_WIDTH-1:0]          wdata_arb_o,
  output logic [$clog2(DEPTH):0]          count_o,
  output logic                            id_err_o
);

  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int A_LSB = DATA_LSB + DATA_WIDTH;
  localparam int T_LSB = A_LSB + ADDR_WIDTH;
  localparam int EW    = T_LSB + TID_WIDTH;

  logic [CW-1:0] count;
  logic [EW-1:0] head;
  logic [EW-1:0] push_dat;
  logic          accept;
  logic          head_v;
  logic          rob_fire;
  logic          arb_fire;
  logic          pop;
  logic          rob_done;
  logic          arb_done;
  logic          id_err;

  // No pop bypass: a full buffer refuses a beat even if the head retires this cycle.
  assign ready_o   = (count < CW'(DEPTH)) & ~empty_i;
  assign accept    = valid_i & ready_o;
  assign read_en_o = accept;
  assign push_dat  = {ar_i, data_i};

  rmh_resp_buf #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept),
    .push_dat (push_dat),
    .pop      (pop),
    .count    (count),
    .head_dat (head)
  );

  assign head_v      = (count != '0);
  assign write_en_o  = head_v & ~rob_done & ~full_i;
  assign valid_o     = head_v & ~arb_done;
  assign rob_fire    = write_en_o;
  assign arb_fire    = valid_o & ready_i;
  assign pop         = head_v & (rob_done | rob_fire) & (arb_done | arb_fire);
  assign wdata_rob_o = {head[T_LSB +: TID_WIDTH], head[DATA_LSB +: DATA_WIDTH]};
  assign wdata_arb_o = {head[A_LSB +: ADDR_WIDTH], head[DATA_LSB +: DATA_WIDTH]};
  assign count_o     = count;
  assign id_err_o    = id_err;

  // Per-side done flags let ROB and Arbiter take the head in different cycles without a resend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rob_done <= 1'b0;
      arb_done <= 1'b0;
    end else if (pop) begin
      rob_done <= 1'b0;
      arb_done <= 1'b0;
    end else begin
      rob_done <= rob_done | rob_fire;
      arb_done <= arb_done | arb_fire;
    end
  end

  if (CHECK_ID) begin : g_id_chk
    logic id_mism;
    assign id_mism = (rid_i != ar_i[ADDR_WIDTH +: ID_WIDTH]);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) id_err <= 1'b0;
      else        id_err <= id_err | (accept & id_mism);
    end
  end else begin : g_no_id_chk
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) id_err <= 1'b0;
      else        id_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_read_miss_handler_mo.sv
// Directed bench for read_miss_handler_mo: per-scenario tasks plus an in-order scoreboard on both fork sides.
module tb_read_miss_handler_mo;
  import rmh_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int TW = 4;
  localparam int IW = 4;
  localparam int DEPTH = 4;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid_i;
  logic              ready_o;
  logic [DW-1:0]     data_i;
  logic [IW-1:0]     rid_i;
  logic              read_en_o;
  logic              empty_i;
  logic [AW+TW-1:0]  ar_i;
  logic              write_en_o;
  logic              full_i;
  logic [DW+TW-1:0]  wdata_rob_o;
  logic              valid_o;
  logic              ready_i;
  logic [AW+DW-1:0]  wdata_arb_o;
  logic [CW-1:0]     count_o;
  logic              id_err_o;

  read_miss_handler_mo #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .TID_WIDTH (TW), .ID_WIDTH (IW),
    .DEPTH (DEPTH), .CHECK_ID (1'b1), .WDATA_WIDTH (AW+DW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .valid_i (valid_i), .ready_o (ready_o),
    .data_i (data_i), .rid_i (rid_i), .read_en_o (read_en_o), .empty_i (empty_i),
    .ar_i (ar_i), .write_en_o (write_en_o), .full_i (full_i), .wdata_rob_o (wdata_rob_o),
    .valid_o (valid_o), .ready_i (ready_i), .wdata_arb_o (wdata_arb_o),
    .count_o (count_o), .id_err_o (id_err_o)
  );

  always #5 clk = ~clk;

  logic [AW+TW-1:0] mq[$];       // miss FIFO: {tid, addr}
  logic [IW+DW-1:0] dq[$];       // CXL beats: {rid, data}
  logic [TW+DW-1:0] exp_rob[$];
  logic [AW+DW-1:0] exp_arb[$];
  logic cxl_en = 1'b0;
  logic full_r = 1'b0;
  logic rdy_r  = 1'b1;
  int n_cmp  = 0;
  int n_fail = 0;
  int n_rob  = 0;
  int n_arb  = 0;

  task automatic drive();
    empty_i = (mq.size() == 0);
    ar_i    = empty_i ? '0 : mq[0];
    valid_i = cxl_en && (dq.size() != 0);
    data_i  = valid_i ? dq[0][DW-1:0] : '0;
    rid_i   = valid_i ? dq[0][DW+IW-1:DW] : '0;
    full_i  = full_r;
    ready_i = rdy_r;
  endtask

  // Scores the current cycle, then advances to just after the next rising edge with inputs settled.
  task automatic tick();
    logic [TW+DW-1:0] er;
    logic [AW+DW-1:0] ea;
    if (rst_n) begin
      if (valid_i && ready_o) begin
        n_cmp++;
        if (mq.size() == 0) begin
          n_fail++;
          $display("FAIL accept_on_empty: got ready_o=1 want 0 with empty miss FIFO");
        end else begin
          exp_rob.push_back({mq[0][AW+TW-1:AW], dq[0][DW-1:0]});
          exp_arb.push_back({mq[0][AW-1:0], dq[0][DW-1:0]});
          void'(mq.pop_front());
          void'(dq.pop_front());
        end
      end
      if (write_en_o) begin
        n_rob++;
        n_cmp++;
        if (exp_rob.size() == 0) begin
          n_fail++;
          $display("FAIL rob_unexpected: got write %h want none", wdata_rob_o);
        end else begin
          er = exp_rob.pop_front();
          if (wdata_rob_o !== er) begin
            n_fail++;
            $display("FAIL rob_order: got %h want %h", wdata_rob_o, er);
          end
        end
      end
      if (valid_o && ready_i) begin
        n_arb++;
        n_cmp++;
        if (exp_arb.size() == 0) begin
          n_fail++;
          $display("FAIL arb_unexpected: got send %h want none", wdata_arb_o);
        end else begin
          ea = exp_arb.pop_front();
          if (wdata_arb_o !== ea) begin
            n_fail++;
            $display("FAIL arb_order: got %h want %h", wdata_arb_o, ea);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    drive();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive();
    #1;
    n_cmp++; if ({write_en_o, valid_o, read_en_o, id_err_o} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b want 0000", {write_en_o, valid_o, read_en_o, id_err_o});
    end
    n_cmp++; if (count_o !== 3'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", count_o);
    end
    n_cmp++; if (wdata_rob_o !== '0 || wdata_arb_o !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h want 0", wdata_rob_o, wdata_arb_o);
    end
    n_cmp++; if (ready_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_empty: got %b want 0", ready_o);
    end
    mq.push_back({4'd1, 32'h0});
    drive();
    #1;
    n_cmp++; if (ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_nonempty: got %b want 1", ready_o);
    end
    mq.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
    #1;
  endtask

  task automatic test_single();
    mq.push_back({4'd3, 32'h0000_1000});
    dq.push_back({4'd3, 64'hAAAA_AAAA_AAAA_AAAA});
    cxl_en = 1'b1; full_r = 1'b0; rdy_r = 1'b1;
    drive();
    #1;
    n_cmp++; if ({read_en_o, write_en_o, valid_o} !== 3'b100) begin
      n_fail++; $display("FAIL single_accept: got %b want 100", {read_en_o, write_en_o, valid_o});
    end
    tick();
    n_cmp++; if (write_en_o !== 1'b1 || wdata_rob_o !== {4'd3, 64'hAAAA_AAAA_AAAA_AAAA}) begin
      n_fail++; $display("FAIL single_rob: got %b %h want 1 3aaaaaaaaaaaaaaaa", write_en_o, wdata_rob_o);
    end
    n_cmp++; if (valid_o !== 1'b1 || wdata_arb_o !== {32'h0000_1000, 64'hAAAA_AAAA_AAAA_AAAA}) begin
      n_fail++; $display("FAIL single_arb: got %b %h want 1 00001000aaaaaaaaaaaaaaaa", valid_o, wdata_arb_o);
    end
    n_cmp++; if (count_o !== 3'd1 || read_en_o !== 1'b0) begin
      n_fail++; $display("FAIL single_count1: got %0d/%b want 1/0", count_o, read_en_o);
    end
    tick();
    n_cmp++; if (count_o !== 3'd0 || id_err_o !== 1'b0 || write_en_o !== 1'b0 || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: got cnt=%0d err=%b we=%b v=%b want 0 0 0 0",
                         count_o, id_err_o, write_en_o, valid_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      mq.push_back({TW'(i), 32'h0000_2000 + 32'(i * 64)});
      dq.push_back({IW'(i), 64'hD000_0000_0000_0000 | 64'(i)});
    end
    drive();
    #1;
    for (int k = 0; k <= 8; k++) begin
      n_cmp++; if (ready_o !== (k < 8)) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got %b want %b", k, ready_o, (k < 8));
      end
      if (k >= 1) begin
        n_cmp++; if (write_en_o !== 1'b1 || wdata_rob_o[DW +: TW] !== TW'(k - 1) || count_o !== 3'd1) begin
          n_fail++; $display("FAIL b2b_stream[%0d]: got we=%b tid=%0d cnt=%0d want 1 %0d 1",
                             k, write_en_o, wdata_rob_o[DW +: TW], count_o, k - 1);
        end
      end
      tick();
    end
    n_cmp++; if (count_o !== 3'd0) begin
      n_fail++; $display("FAIL b2b_drain: got %0d want 0", count_o);
    end
  endtask

  task automatic test_fork_skew();
    int rob0, arb0;
    rob0 = n_rob; arb0 = n_arb;
    full_r = 1'b1; rdy_r = 1'b1;
    mq.push_back({4'd4, 32'h0000_3000}); dq.push_back({4'd4, 64'h1111_0000_0000_0004});
    mq.push_back({4'd5, 32'h0000_3040}); dq.push_back({4'd5, 64'h1111_0000_0000_0005});
    drive();
    #1;
    n_cmp++; if (read_en_o !== 1'b1) begin
      n_fail++; $display("FAIL skew_t0: got read_en=%b want 1", read_en_o);
    end
    tick();
    n_cmp++; if ({valid_o, write_en_o} !== 2'b10) begin
      n_fail++; $display("FAIL skew_t1: got v/we=%b want 10", {valid_o, write_en_o});
    end
    tick();
    n_cmp++; if ({valid_o, write_en_o} !== 2'b00 || count_o !== 3'd2) begin
      n_fail++; $display("FAIL skew_t2: got v/we=%b cnt=%0d want 00 2", {valid_o, write_en_o}, count_o);
    end
    tick();
    n_cmp++; if ({valid_o, write_en_o} !== 2'b00) begin
      n_fail++; $display("FAIL skew_t3: got v/we=%b want 00", {valid_o, write_en_o});
    end
    tick();
    full_r = 1'b0;
    drive();
    #1;
    n_cmp++; if ({valid_o, write_en_o} !== 2'b01 || count_o !== 3'd2) begin
      n_fail++; $display("FAIL skew_t4: got v/we=%b cnt=%0d want 01 2", {valid_o, write_en_o}, count_o);
    end
    tick();
    n_cmp++; if ({valid_o, write_en_o} !== 2'b11 || count_o !== 3'd1) begin
      n_fail++; $display("FAIL skew_t5: got v/we=%b cnt=%0d want 11 1", {valid_o, write_en_o}, count_o);
    end
    tick();
    n_cmp++; if (count_o !== 3'd0 || n_arb - arb0 != 2 || n_rob - rob0 != 2) begin
      n_fail++; $display("FAIL skew_totals: got cnt=%0d arb=%0d rob=%0d want 0 2 2",
                         count_o, n_arb - arb0, n_rob - rob0);
    end
  endtask

  task automatic test_backpressure();
    int guard;
    full_r = 1'b0; rdy_r = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mq.push_back({TW'(8 + i), 32'h0000_4000 + 32'(i * 64)});
      dq.push_back({IW'(8 + i), 64'hBEEF_0000_0000_0000 | 64'(i)});
    end
    drive();
    #1;
    repeat (4) tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (count_o !== 3'd4 || ready_o !== 1'b0 || read_en_o !== 1'b0 || valid_i !== 1'b1) begin
        n_fail++; $display("FAIL bp_full[%0d]: got cnt=%0d rdy=%b ren=%b want 4 0 0", k, count_o, ready_o, read_en_o);
      end
      n_cmp++; if ({valid_o, write_en_o} !== 2'b10) begin
        n_fail++; $display("FAIL bp_head[%0d]: got v/we=%b want 10", k, {valid_o, write_en_o});
      end
      if (k == 0) tick();
    end
    rdy_r = 1'b1;
    drive();
    #1;
    n_cmp++; if (ready_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_bypass: got ready_o=%b want 0", ready_o);
    end
    tick();
    n_cmp++; if (ready_o !== 1'b1 || read_en_o !== 1'b1 || count_o !== 3'd3) begin
      n_fail++; $display("FAIL bp_resume: got rdy=%b ren=%b cnt=%0d want 1 1 3", ready_o, read_en_o, count_o);
    end
    guard = 0;
    while ((count_o != 0 || mq.size() != 0) && guard < 20) begin
      tick();
      guard++;
    end
    n_cmp++; if (guard >= 20 || exp_rob.size() != 0 || exp_arb.size() != 0) begin
      n_fail++; $display("FAIL bp_drain: got guard=%0d pend_rob=%0d pend_arb=%0d want <20 0 0",
                         guard, exp_rob.size(), exp_arb.size());
    end
  endtask

  task automatic test_empty_id();
    dq.push_back({4'd5, 64'h5555_0000_0000_0002});
    drive();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (ready_o !== 1'b0 || read_en_o !== 1'b0 || count_o !== 3'd0) begin
        n_fail++; $display("FAIL empty_fifo[%0d]: got rdy=%b ren=%b cnt=%0d want 0 0 0", k, ready_o, read_en_o, count_o);
      end
      tick();
    end
    mq.push_back({4'd2, 32'h0000_5000});
    drive();
    #1;
    n_cmp++; if (read_en_o !== 1'b1 || id_err_o !== 1'b0) begin
      n_fail++; $display("FAIL id_pre: got ren=%b err=%b want 1 0", read_en_o, id_err_o);
    end
    tick();
    n_cmp++; if (id_err_o !== 1'b1 || write_en_o !== 1'b1 || wdata_rob_o !== {4'd2, 64'h5555_0000_0000_0002}) begin
      n_fail++; $display("FAIL id_err_set: got err=%b we=%b %h want 1 1 25555000000000002", id_err_o, write_en_o, wdata_rob_o);
    end
    tick();
    tick();
    n_cmp++; if (id_err_o !== 1'b1 || count_o !== 3'd0) begin
      n_fail++; $display("FAIL id_sticky: got err=%b cnt=%0d want 1 0", id_err_o, count_o);
    end
  endtask

  task automatic test_reset_mid();
    int rob0, arb0;
    full_r = 1'b1; rdy_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mq.push_back({TW'(i), 32'h0000_6000 + 32'(i * 64)});
      dq.push_back({IW'(i), 64'h6666_0000_0000_0000 | 64'(i)});
    end
    drive();
    #1;
    repeat (3) tick();
    n_cmp++; if (count_o !== 3'd3) begin
      n_fail++; $display("FAIL rst_mid_fill: got %0d want 3", count_o);
    end
    #2;
    rst_n = 1'b0;
    cxl_en = 1'b0;
    mq.delete(); dq.delete(); exp_rob.delete(); exp_arb.delete();
    drive();
    #1;
    n_cmp++; if ({write_en_o, valid_o, read_en_o, id_err_o} !== 4'b0 || count_o !== 3'd0) begin
      n_fail++; $display("FAIL rst_mid_async: got ctl=%b cnt=%0d want 0000 0",
                         {write_en_o, valid_o, read_en_o, id_err_o}, count_o);
    end
    n_cmp++; if (wdata_rob_o !== '0 || wdata_arb_o !== '0) begin
      n_fail++; $display("FAIL rst_mid_data: got %h/%h want 0", wdata_rob_o, wdata_arb_o);
    end
    full_r = 1'b0; rdy_r = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
    #1;
    rob0 = n_rob; arb0 = n_arb;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (count_o !== 3'd0 || write_en_o !== 1'b0 || valid_o !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_stale[%0d]: got cnt=%0d we=%b v=%b want 0 0 0", k, count_o, write_en_o, valid_o);
      end
      tick();
    end
    n_cmp++; if (n_rob != rob0 || n_arb != arb0) begin
      n_fail++; $display("FAIL rst_mid_writes: got rob=%0d arb=%0d want 0 0", n_rob - rob0, n_arb - arb0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fork_skew();
    test_backpressure();
    test_empty_id();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
